store_commit_buffer: RTL and testbench

Post-retirement store buffer at the drain end of the store queue. Accepts up to N retired stores per cycle from the store-queue head, holds them in order, and issues them one at a time to the data-memory write port with a valid/ready handshake. Retired stores are architectural, so mispredict never clears this block. An `empty` indication supports fence and halt.

---
 rtl/store_commit_buffer.sv | 188 ++++++++++++++++++
 tb/tb_store_commit_buffer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_commit_buffer.sv
// Post-retirement store buffer draining retired stores in order to memory.
// Optional load forwarding is compiled in when STORE_BUF_FWD_EN is defined.
module store_commit_buffer #(
  parameter int DEPTH  = 8,
  parameter int N      = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [N-1:0]             retire_valid,
  input  logic [N*ADDR_W-1:0]      retire_addr,
  input  logic [N*DATA_W-1:0]      retire_data,
  input  logic [N*2-1:0]           retire_size,
  output logic [$clog2(DEPTH+1)-1:0] free_entries,
  output logic                     mem_req_valid,
  output logic [ADDR_W-1:0]        mem_req_addr,
  output logic [DATA_W-1:0]        mem_req_data,
  output logic [1:0]               mem_req_size,
  input  logic                     mem_req_ready,
`ifdef STORE_BUF_FWD_EN
  input  logic [ADDR_W-1:0]        ld_fwd_addr,
  input  logic [1:0]               ld_fwd_size,
  output logic                     ld_fwd_hit,
  output logic [DATA_W-1:0]        ld_fwd_data,
  output logic                     ld_fwd_partial,
`endif
  output logic                     empty,
  output logic                     overflow_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam int unsigned DEPTH_U = DEPTH;

  function automatic logic [PW-1:0] wrap_add(
    input logic [PW-1:0] p,
    input int unsigned   k
  );
    int unsigned s;
    s = int'(p) + k;
    if (s >= DEPTH_U) s = s - DEPTH_U;
    return s[PW-1:0];
  endfunction

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [1:0]        size_q [DEPTH];
  logic [1:0]        size_d [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] free_q, free_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;

  logic [CW-1:0] n_in;
  logic          accept;
  logic          pop;
  logic [PW-1:0] widx;
  int unsigned   slot;

  assign mem_req_valid = (count_q != '0);
  assign mem_req_addr  = addr_q[head_q];
  assign mem_req_data  = data_q[head_q];
  assign mem_req_size  = size_q[head_q];
  assign free_entries  = free_q;
  assign empty         = empty_q;
  assign overflow_err  = ovf_q;

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    size_d = size_q;
    n_in   = '0;
    slot   = 0;
    widx   = '0;
    for (int i = 0; i < N; i++)
      n_in = n_in + CW'(retire_valid[i]);
    // capacity uses last cycle's free count; a pop never makes room
    accept = (n_in <= free_q);
    pop    = mem_req_valid && mem_req_ready;
    for (int i = 0; i < N; i++) begin
      if (accept && retire_valid[i]) begin
        widx         = wrap_add(tail_q, slot);
        addr_d[widx] = retire_addr[i*ADDR_W +: ADDR_W];
        data_d[widx] = retire_data[i*DATA_W +: DATA_W];
        size_d[widx] = retire_size[i*2 +: 2];
        slot         = slot + 1;
      end
    end
    head_d  = pop ? wrap_add(head_q, 1) : head_q;
    tail_d  = accept ? wrap_add(tail_q, int'(n_in)) : tail_q;
    count_d = count_q + (accept ? n_in : '0) - CW'(pop);
    free_d  = CW'(DEPTH) - count_d;
    empty_d = (count_d == '0);
    ovf_d   = ovf_q | ~accept;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      free_q  <= CW'(DEPTH);
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      free_q  <= free_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n) begin
      addr_q <= addr_d;
      data_q <= data_d;
      size_q <= size_d;
    end
  end

`ifdef STORE_BUF_FWD_EN
  localparam int OW = (DATA_W > 8) ? $clog2(DATA_W/8) : 1;

  function automatic logic [ADDR_W:0] nbytes(input logic [1:0] s);
    unique case (1'b1)
      (s == 2'd0): nbytes = (ADDR_W+1)'(1);
      (s == 2'd1): nbytes = (ADDR_W+1)'(2);
      default:     nbytes = (ADDR_W+1)'(DATA_W/8);
    endcase
  endfunction

  logic          f_hit, f_part;
  logic [DATA_W-1:0] f_raw, f_mask;
  logic [ADDR_W:0]   la, lb, sa, sb, off;
  logic [PW-1:0]     fidx;
  logic              cov, ovl;

  always_comb begin
    f_hit  = 1'b0;
    f_part = 1'b0;
    f_raw  = '0;
    fidx   = '0;
    sa     = '0;
    sb     = '0;
    off    = '0;
    cov    = 1'b0;
    ovl    = 1'b0;
    la     = {1'b0, ld_fwd_addr};
    lb     = nbytes(ld_fwd_size);
    // walk oldest to youngest so the youngest match wins
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count_q) begin
        fidx = wrap_add(head_q, k);
        sa   = {1'b0, addr_q[fidx]};
        sb   = nbytes(size_q[fidx]);
        cov  = (sa <= la) && (la + lb <= sa + sb);
        ovl  = (sa < la + lb) && (la < sa + sb);
        if (cov) begin
          off    = la - sa;
          f_raw  = data_q[fidx] >> {off[OW-1:0], 3'b000};
          f_hit  = 1'b1;
          f_part = 1'b0;
        end else if (ovl) begin
          f_part = 1'b1;
        end
      end
    end
    unique case (1'b1)
      (ld_fwd_size == 2'd0): f_mask = DATA_W'(8'hFF);
      (ld_fwd_size == 2'd1): f_mask = DATA_W'(16'hFFFF);
      default:               f_mask = '1;
    endcase
  end

  assign ld_fwd_partial = f_part;
  assign ld_fwd_hit     = f_hit && !f_part;
  assign ld_fwd_data    = f_raw & f_mask;
`endif

endmodule

// File: tb/tb_store_commit_buffer.sv
// Bench for store_commit_buffer: directed plan steps then random traffic,
// checked every cycle against a queue-based reference model.
module tb_store_commit_buffer;
  localparam int DEPTH = 8;
  localparam int N     = 3;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH+1);

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    retire_valid = '0;
  logic [N*AW-1:0] retire_addr = '0;
  logic [N*DW-1:0] retire_data = '0;
  logic [N*2-1:0]  retire_size = '0;
  logic [CW-1:0]   free_entries;
  logic            mem_req_valid;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_data;
  logic [1:0]      mem_req_size;
  logic            mem_req_ready = 1'b0;
  logic            empty;
  logic            overflow_err;
`ifdef STORE_BUF_FWD_EN
  logic [AW-1:0]   ld_fwd_addr = '0;
  logic [1:0]      ld_fwd_size = '0;
  logic            ld_fwd_hit;
  logic [DW-1:0]   ld_fwd_data;
  logic            ld_fwd_partial;
`endif

  store_commit_buffer #(
    .DEPTH(DEPTH), .N(N), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .retire_valid  (retire_valid),
    .retire_addr   (retire_addr),
    .retire_data   (retire_data),
    .retire_size   (retire_size),
    .free_entries  (free_entries),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_data  (mem_req_data),
    .mem_req_size  (mem_req_size),
    .mem_req_ready (mem_req_ready),
`ifdef STORE_BUF_FWD_EN
    .ld_fwd_addr   (ld_fwd_addr),
    .ld_fwd_size   (ld_fwd_size),
    .ld_fwd_hit    (ld_fwd_hit),
    .ld_fwd_data   (ld_fwd_data),
    .ld_fwd_partial(ld_fwd_partial),
`endif
    .empty         (empty),
    .overflow_err  (overflow_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [1:0]    s;
  } ent_t;

  ent_t q[$];
  bit   ovf_m = 1'b0;
  int   passed = 0;
  int   total = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("valid", 64'(mem_req_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("addr", 64'(mem_req_addr), 64'(q[0].a));
      chk("data", 64'(mem_req_data), 64'(q[0].d));
      chk("size", 64'(mem_req_size), 64'(q[0].s));
    end
    chk("free", 64'(free_entries), 64'(DEPTH - q.size()));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("ovf", 64'(overflow_err), 64'(ovf_m));
  endtask

  task automatic lane(input int i, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [1:0] s);
    retire_valid[i]          = 1'b1;
    retire_addr[i*AW +: AW]  = a;
    retire_data[i*DW +: DW]  = d;
    retire_size[i*2 +: 2]    = s;
  endtask

  task automatic idle();
    retire_valid = '0;
  endtask

  // reference: pop from the front, then append the whole bundle only if
  // it fits in the room that existed before this edge
  task automatic cycle();
    int n;
    bit pop;
    bit acc;
    ent_t e;
    @(posedge clock);
    if (!reset_n) begin
      q.delete();
      ovf_m = 1'b0;
    end else begin
      n = 0;
      for (int i = 0; i < N; i++) if (retire_valid[i]) n++;
      pop = (q.size() != 0) && mem_req_ready;
      acc = (n <= DEPTH - q.size());
      if (pop) void'(q.pop_front());
      if (acc) begin
        for (int i = 0; i < N; i++) begin
          if (retire_valid[i]) begin
            e.a = retire_addr[i*AW +: AW];
            e.d = retire_data[i*DW +: DW];
            e.s = retire_size[i*2 +: 2];
            q.push_back(e);
          end
        end
      end else begin
        ovf_m = 1'b1;
      end
    end
    @(negedge clock);
    check_all();
  endtask

  initial begin
    // reset
    reset_n = 1'b0;
    cycle();
    cycle();
    chk("rst_free", 64'(free_entries), 64'd8);
    chk("rst_empty", 64'(empty), 64'd1);
    reset_n = 1'b1;

    // step 1: three-lane retire then drain
    mem_req_ready = 1'b1;
    lane(0, 32'h100, 32'hA, 2'd2);
    lane(1, 32'h104, 32'hB, 2'd2);
    lane(2, 32'h108, 32'hC, 2'd2);
    cycle();
    idle();
    chk("s1_free", 64'(free_entries), 64'd5);
    chk("s1_a0", 64'(mem_req_addr), 64'h100);
    cycle();
    chk("s1_a1", 64'(mem_req_addr), 64'h104);
    cycle();
    chk("s1_a2", 64'(mem_req_addr), 64'h108);
    cycle();
    chk("s1_empty", 64'(empty), 64'd1);

    // step 2: backpressure holds payload stable
    mem_req_ready = 1'b0;
    lane(0, 32'h300, 32'hDEAD_BEEF, 2'd1);
    cycle();
    idle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("s2_hold_a", 64'(mem_req_addr), 64'h300);
      chk("s2_hold_d", 64'(mem_req_data), 64'hDEAD_BEEF);
    end
    mem_req_ready = 1'b1;
    cycle();
    chk("s2_drained", 64'(mem_req_valid), 64'd0);

    // step 3: fill, then push 1 with pop at full
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) lane(i, 32'h400 + 32'(4*i), 32'(i), 2'd2);
    cycle();
    for (int i = 0; i < 3; i++) lane(i, 32'h40C + 32'(4*i), 32'(i+3), 2'd2);
    cycle();
    idle();
    for (int i = 0; i < 2; i++) lane(i, 32'h418 + 32'(4*i), 32'(i+6), 2'd2);
    cycle();
    idle();
    chk("s3_full", 64'(free_entries), 64'd0);
    lane(0, 32'h500, 32'h55, 2'd0);
    mem_req_ready = 1'b1;
    cycle();
    idle();
    mem_req_ready = 1'b0;
    chk("s3_ovf", 64'(overflow_err), 64'd1);
    chk("s3_free", 64'(free_entries), 64'd1);
    chk("s3_head", 64'(mem_req_addr), 64'h404);

    // step 5: reset mid-drain with four entries
    mem_req_ready = 1'b1;
    cycle();
    cycle();
    cycle();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    chk("s5_valid", 64'(mem_req_valid), 64'd0);
    chk("s5_free", 64'(free_entries), 64'd8);
    chk("s5_ovf", 64'(overflow_err), 64'd0);

    // step 4: 13 single stores across the wrap
    for (int i = 0; i < 13; i++) begin
      lane(0, 32'h600 + 32'(4*i), 32'(i*7), 2'(i));
      cycle();
      idle();
    end
    cycle();
    chk("s4_free", 64'(free_entries), 64'd8);

`ifdef STORE_BUF_FWD_EN
    // step 6: forwarding
    mem_req_ready = 1'b0;
    lane(0, 32'h200, 32'h1122_3344, 2'd2);
    lane(1, 32'h201, 32'hEE, 2'd0);
    cycle();
    idle();
    ld_fwd_addr = 32'h200;
    ld_fwd_size = 2'd2;
    #1;
    chk("f_part", 64'(ld_fwd_partial), 64'd1);
    chk("f_nohit", 64'(ld_fwd_hit), 64'd0);
    ld_fwd_addr = 32'h201;
    ld_fwd_size = 2'd0;
    #1;
    chk("f_bhit", 64'(ld_fwd_hit), 64'd1);
    chk("f_bdat", 64'(ld_fwd_data), 64'hEE);
    ld_fwd_addr = 32'h202;
    ld_fwd_size = 2'd1;
    #1;
    chk("f_hhit", 64'(ld_fwd_hit), 64'd1);
    chk("f_hdat", 64'(ld_fwd_data), 64'h1122);
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
`endif

    // random traffic
    for (int t = 0; t < 500; t++) begin
      reset_n = ($urandom_range(0, 80) != 0);
      mem_req_ready = ($urandom_range(0, 3) != 0);
      idle();
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) == 0)
          lane(i, $urandom, $urandom, 2'($urandom_range(0, 3)));
      end
      cycle();
    end
    reset_n = 1'b1;
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
